// File: rtl/alu_ops_pkg.sv
// ALU control codes shared by the decoder and the multiply/divide unit,
// plus the state type of the multi-cycle unit.
package alu_ops_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_sign_adjust.sv
// Two's-complement conditional negate: turns a signed value into its magnitude,
// or an unsigned magnitude back into a signed result, truncated to WIDTH bits.
module md_sign_adjust #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? -value : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, results held in hi/lo until the next completion.
module mul_div_unit
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t state, state_next;
  logic busy_next, done_next;
  logic op_valid, accept, iterate, finish, abort;

  logic             is_div;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] mag_a_reg;
  logic [WIDTH-1:0] mag_b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH:0]   mult_wide;
  logic [2*WIDTH-1:0] mult_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res, rem_in, rem_res;

  assign op_valid = (alu_control == ALU_MULT) || (alu_control == ALU_DIV);

  md_sign_adjust #(.WIDTH(WIDTH)) u_mag_a (
    .value(operand_a), .negate(operand_a[WIDTH-1]), .result(mag_a));
  md_sign_adjust #(.WIDTH(WIDTH)) u_mag_b (
    .value(operand_b), .negate(operand_b[WIDTH-1]), .result(mag_b));

  // Product sign applies to the whole double-width word, so it gets its own wide negate.
  md_sign_adjust #(.WIDTH(2*WIDTH)) u_prod (
    .value(acc), .negate(sign_q), .result(prod_res));
  md_sign_adjust #(.WIDTH(WIDTH)) u_quot (
    .value(acc[WIDTH-1:0]), .negate(sign_q), .result(quot_res));
  md_sign_adjust #(.WIDTH(WIDTH)) u_rem (
    .value(rem_in), .negate(sign_r), .result(rem_res));

  // Divide by zero reports the dividend untouched; re-signing its magnitude restores it.
  assign rem_in = div_by_zero ? mag_a_reg : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_reg};
    mult_wide = {mult_sum, acc[WIDTH-1:0]};
    mult_next = acc[0] ? mult_wide[2*WIDTH:1] : {1'b0, acc[2*WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b_reg};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    accept     = 1'b0;
    iterate    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!flush && start && op_valid) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (count == '0) begin
          finish     = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          iterate = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == CALC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      mag_a_reg   <= '0;
      mag_b_reg   <= '0;
      acc         <= '0;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      is_div      <= (alu_control == ALU_DIV);
      sign_q      <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      sign_r      <= operand_a[WIDTH-1];
      mag_a_reg   <= mag_a;
      mag_b_reg   <= mag_b;
      acc         <= (alu_control == ALU_DIV) ? {{WIDTH{1'b0}}, mag_a}
                                              : {{WIDTH{1'b0}}, mag_b};
      count       <= CW'(WIDTH);
      div_by_zero <= (alu_control == ALU_DIV) && (operand_b == '0);
    end else if (iterate) begin
      acc   <= is_div ? div_next : mult_next;
      count <= count - 1'b1;
    end else if (finish) begin
      if (is_div) begin
        hi <= rem_res;
        lo <= div_by_zero ? '1 : quot_res;
      end else begin
        hi <= prod_res[2*WIDTH-1:WIDTH];
        lo <= prod_res[WIDTH-1:0];
      end
    end else if (abort) begin
      div_by_zero <= 1'b0;
    end
  end

endmodule
